uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------------------------
// uart_rx_cfg: configurable UART receiver with a one-word holding register.
//
// The serial line is resynchronised by two flops and then sampled mid-bit by an FSM.
// A free-running timer restarts at each start edge (t0), and every sample point is an
// absolute offset from t0, so rounding never accumulates across the frame.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rstn           synchronous active-low reset
//   rxd_i          asynchronous serial input, idle high
//   err_clr_i      single-cycle pulse that clears oerr_o
//   rdata_o        data from the holding register (LSB received first)
//   rdata_perr_o   parity error flag of the held word
//   rdata_valid_o  holding register full
//   rdata_ready_i  consumer accepts the word when rdata_valid_o is also high
//   ferr_o         one-cycle pulse on a framing error
//   brk_o          one-cycle pulse on break detection
//   oerr_o         sticky overrun flag
// ---------------------------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int unsigned CLK_PER_HALF_BIT = 5208,
   parameter int unsigned DATA_BITS        = 8,
   parameter int unsigned PARITY           = 0,
   parameter int unsigned STOP_BITS        = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 rxd_i,
   input  logic                 err_clr_i,
   output logic [DATA_BITS-1:0] rdata_o,
   output logic                 rdata_perr_o,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   output logic                 ferr_o,
   output logic                 brk_o,
   output logic                 oerr_o
);

   localparam logic [31:0] HalfBit   = 32'(CLK_PER_HALF_BIT);
   localparam logic [31:0] FullBit   = 32'(2 * CLK_PER_HALF_BIT);
   localparam logic [3:0]  LastBit   = 4'(DATA_BITS - 1);
   localparam logic        LastStop  = (STOP_BITS == 2);
   localparam bit          HasParity = (PARITY != 0);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop,
      StBrkWait
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           sync_q;
   logic [31:0]          timer_q, timer_d;
   logic [31:0]          target_q, target_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 stop_err_q, stop_err_d;

   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 perr_q, perr_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;
   logic                 oerr_q, oerr_d;

   logic line;
   logic sample;
   logic load;
   logic par_sum;
   logic perr_calc;
   logic stop_err_now;
   logic xfer;

   assign line = sync_q[1];

   // Parity of data plus received parity bit; par_q is 0 when the frame has no parity.
   assign par_sum = ^{shift_q, par_q};
   always_comb begin
      perr_calc = 1'b0;
      if (PARITY == 1) begin
         perr_calc = par_sum;
      end else if (PARITY == 2) begin
         perr_calc = ~par_sum;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q + 32'd1;
      target_d     = target_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      stop_idx_d   = stop_idx_q;
      stop_err_d   = stop_err_q;
      load         = 1'b0;
      ferr_d       = 1'b0;
      brk_d        = 1'b0;
      sample       = (timer_q == target_q);
      stop_err_now = stop_err_q | ~line;

      case (state_q)
         StIdle: begin
            // Timer reads 0 in the t0 cycle, so timer_q == n in cycle t0+n.
            timer_d = '0;
            if (!line) begin
               state_d  = StStart;
               timer_d  = 32'd1;
               target_d = HalfBit;
            end
         end

         StStart: begin
            if (sample) begin
               if (line) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StData;
                  target_d  = target_q + FullBit;
                  bit_cnt_d = '0;
               end
            end
         end

         StData: begin
            if (sample) begin
               // Shift in from the top so bit i ends up at position i after the last shift.
               shift_d  = {line, shift_q[DATA_BITS-1:1]};
               target_d = target_q + FullBit;
               if (bit_cnt_q == LastBit) begin
                  state_d    = HasParity ? StPar : StStop;
                  par_d      = 1'b0;
                  stop_idx_d = 1'b0;
                  stop_err_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end

         StPar: begin
            if (sample) begin
               par_d    = line;
               target_d = target_q + FullBit;
               state_d  = StStop;
            end
         end

         StStop: begin
            if (sample) begin
               if (!stop_idx_q && !line && (shift_q == '0) && !par_q) begin
                  // All-zero frame with a low first stop bit: break, not a framing error.
                  brk_d   = 1'b1;
                  state_d = StBrkWait;
               end else if (stop_idx_q == LastStop) begin
                  state_d = StIdle;
                  if (stop_err_now) begin
                     ferr_d = 1'b1;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  stop_idx_d = 1'b1;
                  stop_err_d = stop_err_now;
                  target_d   = target_q + FullBit;
               end
            end
         end

         StBrkWait: begin
            if (line) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Holding register and error flags
   // ------------------------------------------------------------------------------------------
   assign xfer = valid_q & rdata_ready_i;

   always_comb begin
      rdata_d = rdata_q;
      perr_d  = perr_q;
      valid_d = valid_q;
      oerr_d  = oerr_q;

      if (err_clr_i) begin
         oerr_d = 1'b0;
      end

      if (load) begin
         if (!valid_q || xfer) begin
            rdata_d = shift_q;
            perr_d  = perr_calc;
            valid_d = 1'b1;
         end else begin
            // Overrun: the old word stays, the new one is dropped; set beats clear.
            oerr_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         sync_q     <= 2'b11;
         timer_q    <= '0;
         target_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         stop_idx_q <= 1'b0;
         stop_err_q <= 1'b0;
         rdata_q    <= '0;
         perr_q     <= 1'b0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
         oerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], rxd_i};
         timer_q    <= timer_d;
         target_q   <= target_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         stop_idx_q <= stop_idx_d;
         stop_err_q <= stop_err_d;
         rdata_q    <= rdata_d;
         perr_q     <= perr_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
         oerr_q     <= oerr_d;
      end
   end

   assign rdata_o       = rdata_q;
   assign rdata_perr_o  = perr_q;
   assign rdata_valid_o = valid_q;
   assign ferr_o        = ferr_q;
   assign brk_o         = brk_q;
   assign oerr_o        = oerr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg with H=4.
//   u_8n1 : 8 data, no parity, 1 stop
//   u_8e1 : 8 data, even parity, 1 stop
//   u_8n2 : 8 data, no parity, 2 stops
// Frames are driven as whole bit periods of 2H cycles on rxd; a negedge monitor counts
// valid rises, high cycles and flag pulses, and checks compare against bench-side values.
// ---------------------------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] rxd;
   logic [2:0] ready;
   logic [2:0] err_clr;
   logic [7:0] rdata [3];
   logic       perr  [3];
   logic       valid [3];
   logic       ferr  [3];
   logic       brk   [3];
   logic       oerr  [3];

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rstn(rstn), .rxd_i(rxd[0]), .err_clr_i(err_clr[0]), .rdata_o(rdata[0]),
      .rdata_perr_o(perr[0]), .rdata_valid_o(valid[0]), .rdata_ready_i(ready[0]),
      .ferr_o(ferr[0]), .brk_o(brk[0]), .oerr_o(oerr[0]));

   uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rstn(rstn), .rxd_i(rxd[1]), .err_clr_i(err_clr[1]), .rdata_o(rdata[1]),
      .rdata_perr_o(perr[1]), .rdata_valid_o(valid[1]), .rdata_ready_i(ready[1]),
      .ferr_o(ferr[1]), .brk_o(brk[1]), .oerr_o(oerr[1]));

   uart_rx_cfg #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rstn(rstn), .rxd_i(rxd[2]), .err_clr_i(err_clr[2]), .rdata_o(rdata[2]),
      .rdata_perr_o(perr[2]), .rdata_valid_o(valid[2]), .rdata_ready_i(ready[2]),
      .ferr_o(ferr[2]), .brk_o(brk[2]), .oerr_o(oerr[2]));

   // ---------------------------------------------------------------- monitor
   int         cyc = 0;
   int         start_cyc = 0;
   int         rise_cnt [3] = '{0, 0, 0};
   int         rise_cyc [3] = '{0, 0, 0};
   int         hi_cnt   [3] = '{0, 0, 0};
   int         ferr_cnt [3] = '{0, 0, 0};
   int         brk_cnt  [3] = '{0, 0, 0};
   logic [8:0] last_word [3];
   logic       vprev [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (valid[k] === 1'b1 && vprev[k] !== 1'b1) begin
            rise_cnt[k]++;
            rise_cyc[k]  = cyc;
            last_word[k] = {perr[k], rdata[k]};
         end
         if (valid[k] === 1'b1) hi_cnt[k]++;
         if (ferr[k] === 1'b1) ferr_cnt[k]++;
         if (brk[k] === 1'b1) brk_cnt[k]++;
         vprev[k] = valid[k];
      end
   end

   // ---------------------------------------------------------------- checking helpers
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Drive one frame on line d: start, 8 data LSB first, optional parity, nstop stop bits.
   task automatic send(input int d, input logic [7:0] data, input bit haspar, input logic pbit,
                       input int nstop, input logic s1, input logic s2);
      logic bits [$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (haspar) bits.push_back(pbit);
      bits.push_back(s1);
      if (nstop == 2) bits.push_back(s2);
      @(negedge clk);
      start_cyc = cyc;
      foreach (bits[i]) begin
         rxd[d] = bits[i];
         repeat (2 * H) @(negedge clk);
      end
      rxd[d] = 1'b1;
   endtask

   // Send a frame and check which outcome it produced (valid rise / ferr / brk) and the word.
   task automatic frame_check(input string name, input int d, input logic [7:0] data,
                              input bit haspar, input logic pbit, input int nstop,
                              input logic s1, input logic s2, input int exp_kind,
                              input logic [8:0] exp_word);
      int r0, f0, b0;
      r0 = rise_cnt[d];
      f0 = ferr_cnt[d];
      b0 = brk_cnt[d];
      send(d, data, haspar, pbit, nstop, s1, s2);
      repeat (2) @(negedge clk);
      settle();
      check({name, ".valid"}, rise_cnt[d] - r0, (exp_kind == 0) ? 1 : 0);
      check({name, ".ferr"}, ferr_cnt[d] - f0, (exp_kind == 1) ? 1 : 0);
      check({name, ".brk"}, brk_cnt[d] - b0, (exp_kind == 2) ? 1 : 0);
      if (exp_kind == 0) check({name, ".word"}, 32'(last_word[d]), 32'(exp_word));
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         kind;      // 0 good word, 1 framing error, 2 break
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   // ---------------------------------------------------------------- test sequence
   initial begin
      int r0, f0, b0, h0;
      logic [7:0] rd;
      logic       pb;
      logic       exp_perr;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, kind: 0, exp_data: 8'hA5};
      vecs[1] = '{data: 8'h3C, stop: 1'b0, kind: 1, exp_data: 8'h00};
      vecs[2] = '{data: 8'h00, stop: 1'b0, kind: 2, exp_data: 8'h00};
      vecs[3] = '{data: 8'h00, stop: 1'b1, kind: 0, exp_data: 8'h00};
      vecs[4] = '{data: 8'hFF, stop: 1'b1, kind: 0, exp_data: 8'hFF};
      vecs[5] = '{data: 8'h80, stop: 1'b0, kind: 1, exp_data: 8'h00};
      vecs[6] = '{data: 8'h01, stop: 1'b1, kind: 0, exp_data: 8'h01};
      vecs[7] = '{data: 8'h7E, stop: 1'b1, kind: 0, exp_data: 8'h7E};

      rstn    = 1'b0;
      rxd     = 3'b111;
      ready   = 3'b111;
      err_clr = 3'b000;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      settle();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset.rdata%0d", k), 32'(rdata[k]), 0);
         check($sformatf("reset.perr%0d", k), 32'(perr[k]), 0);
         check($sformatf("reset.valid%0d", k), 32'(valid[k]), 0);
         check($sformatf("reset.ferr%0d", k), 32'(ferr[k]), 0);
         check($sformatf("reset.brk%0d", k), 32'(brk[k]), 0);
         check($sformatf("reset.oerr%0d", k), 32'(oerr[k]), 0);
      end

      // Exact latency: line low seen after 2 sync flops, valid at t0+77 for one cycle.
      h0 = hi_cnt[0];
      r0 = rise_cnt[0];
      send(0, 8'hA5, 0, 1'b0, 1, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      settle();
      check("a5.rise", rise_cnt[0] - r0, 1);
      check("a5.latency", rise_cyc[0] - start_cyc, 79);
      check("a5.width", hi_cnt[0] - h0, 1);
      check("a5.word", 32'(last_word[0]), 32'h0A5);

      // Table-driven 8N1 frames.
      for (int i = 0; i < 8; i++) begin
         frame_check($sformatf("vec%0d", i), 0, vecs[i].data, 0, 1'b0, 1, vecs[i].stop, 1'b1,
                     vecs[i].kind, {1'b0, vecs[i].exp_data});
      end

      // False start: 3 low cycles only.
      r0 = rise_cnt[0]; f0 = ferr_cnt[0]; b0 = brk_cnt[0];
      @(negedge clk);
      rxd[0] = 1'b0;
      repeat (3) @(negedge clk);
      rxd[0] = 1'b1;
      repeat (30) @(negedge clk);
      settle();
      check("glitch.valid", rise_cnt[0] - r0, 0);
      check("glitch.ferr", ferr_cnt[0] - f0, 0);
      check("glitch.brk", brk_cnt[0] - b0, 0);
      frame_check("after_glitch", 0, 8'h5A, 0, 1'b0, 1, 1'b1, 1'b1, 0, 9'h05A);

      // Break: 12 bit times low, then a normal frame.
      r0 = rise_cnt[0]; f0 = ferr_cnt[0]; b0 = brk_cnt[0];
      @(negedge clk);
      rxd[0] = 1'b0;
      repeat (12 * 2 * H) @(negedge clk);
      rxd[0] = 1'b1;
      repeat (10) @(negedge clk);
      settle();
      check("break.brk", brk_cnt[0] - b0, 1);
      check("break.ferr", ferr_cnt[0] - f0, 0);
      check("break.valid", rise_cnt[0] - r0, 0);
      frame_check("after_break", 0, 8'h7E, 0, 1'b0, 1, 1'b1, 1'b1, 0, 9'h07E);

      // Overrun with consumer stalled, then err_clr.
      ready[0] = 1'b0;
      send(0, 8'h11, 0, 1'b0, 1, 1'b1, 1'b1);
      settle();
      check("ovr.first_oerr", 32'(oerr[0]), 0);
      send(0, 8'h22, 0, 1'b0, 1, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      settle();
      check("ovr.rdata", 32'(rdata[0]), 32'h11);
      check("ovr.valid", 32'(valid[0]), 1);
      check("ovr.oerr", 32'(oerr[0]), 1);
      @(negedge clk);
      err_clr[0] = 1'b1;
      @(negedge clk);
      err_clr[0] = 1'b0;
      settle();
      check("ovr.cleared", 32'(oerr[0]), 0);

      // Consume in the exact load cycle: new word taken, valid stays, no overrun.
      fork
         send(0, 8'h33, 0, 1'b0, 1, 1'b1, 1'b1);
         begin
            @(negedge clk);
            repeat (78) @(negedge clk);
            ready[0] = 1'b1;
            @(negedge clk);
            ready[0] = 1'b0;
         end
      join
      settle();
      check("same_cycle.rdata", 32'(rdata[0]), 32'h33);
      check("same_cycle.valid", 32'(valid[0]), 1);
      check("same_cycle.oerr", 32'(oerr[0]), 0);
      @(negedge clk);
      ready[0] = 1'b1;
      @(negedge clk);
      settle();
      check("drain.valid", 32'(valid[0]), 0);

      // Even parity on u_8e1.
      frame_check("par03_1", 1, 8'h03, 1, 1'b1, 1, 1'b1, 1'b1, 0, 9'h103);
      frame_check("par03_0", 1, 8'h03, 1, 1'b0, 1, 1'b1, 1'b1, 0, 9'h003);

      // Randomised parity frames against an arithmetic model.
      for (int i = 0; i < 24; i++) begin
         rd = 8'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         exp_perr = ((($countones(rd) + int'(pb)) % 2) == 1);
         frame_check($sformatf("rnd%0d", i), 1, rd, 1, pb, 1, 1'b1, 1'b1, 0, {exp_perr, rd});
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Two stop bits on u_8n2.
      frame_check("s2_good", 2, 8'h3C, 0, 1'b0, 2, 1'b1, 1'b1, 0, 9'h03C);
      frame_check("s2_second0", 2, 8'h3C, 0, 1'b0, 2, 1'b1, 1'b0, 1, 9'h000);
      frame_check("s2_first0", 2, 8'h3C, 0, 1'b0, 2, 1'b0, 1'b1, 1, 9'h000);
      frame_check("s2_break", 2, 8'h00, 0, 1'b0, 2, 1'b0, 1'b1, 2, 9'h000);
      frame_check("s2_after", 2, 8'hC5, 0, 1'b0, 2, 1'b1, 1'b1, 0, 9'h0C5);

      // Reset in the middle of a frame.
      r0 = rise_cnt[0]; f0 = ferr_cnt[0]; b0 = brk_cnt[0];
      @(negedge clk);
      rxd[0] = 1'b0;
      repeat (40) @(negedge clk);
      rstn   = 1'b0;
      rxd[0] = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      settle();
      check("midrst.valid1", 32'(valid[1]), 0);
      check("midrst.rdata1", 32'(rdata[1]), 0);
      repeat (100) @(negedge clk);
      settle();
      check("midrst.valid", rise_cnt[0] - r0, 0);
      check("midrst.ferr", ferr_cnt[0] - f0, 0);
      check("midrst.brk", brk_cnt[0] - b0, 0);
      frame_check("after_rst", 0, 8'hC3, 0, 1'b0, 1, 1'b1, 1'b1, 0, 9'h0C3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
